// File: rtl/seq_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Optional comparator outputs are enabled by defining SEQ_SUB_CMP_EN.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_DEFAULT = 4;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_sub_digit.sv
// Combinational DIGIT-bit subtractor: {bout, d} = a - b - bin, built as a
// bit-level borrow chain so it maps onto the fabric carry logic.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
    // A borrow leaves this bit when b exceeds a, or when they match and a borrow came in.
    assign d[gi]       = a[gi] ^ b[gi] ^ brw[gi];
    assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
  end

  assign bout = brw[DIGIT];

endmodule

// File: rtl/seq_sub.sv
// Digit-serial subtractor, DIGIT bits per cycle, LSB digit first, with
// valid/ready on both sides. Define SEQ_SUB_CMP_EN to add lt/eq outputs.
module seq_sub
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SEQ_SUB_CMP_EN
  output logic             lt,
  output logic             eq,
`endif
  output logic             ovf
);

  localparam int NDIG  = ndig(WIDTH, DIGIT);
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : g_width_check
    $error("seq_sub: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_sign_q, a_sign_d;
  logic             b_sign_q, b_sign_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef SEQ_SUB_CMP_EN
  logic             zero_q, zero_d;
`endif

  logic [DIGIT-1:0] dig_d;
  logic             dig_bout;

  // Operands are shifted right each cycle so the active digit is always the low slice.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[DIGIT-1:0]),
    .b    (b_q[DIGIT-1:0]),
    .bin  (brw_q),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    brw_d       = brw_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_SUB_CMP_EN
    zero_d      = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          a_sign_d   = a[WIDTH-1];
          b_sign_d   = b[WIDTH-1];
          brw_d      = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
`ifdef SEQ_SUB_CMP_EN
          zero_d     = 1'b1;
`endif
        end
      end
      RUN: begin
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        brw_d  = dig_bout;
        cnt_d  = cnt_q + CNT_W'(1);
        diff_d = diff_q >> DIGIT;
        diff_d[WIDTH-1 -: DIGIT] = dig_d;
`ifdef SEQ_SUB_CMP_EN
        zero_d = zero_q & (dig_d == '0);
`endif
        if (cnt_q == CNT_LAST) begin
          // The last digit carries the result sign bit.
          bout_d  = dig_bout;
          ovf_d   = (a_sign_q != b_sign_q) & (dig_d[DIGIT-1] != a_sign_q);
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_SUB_CMP_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      brw_q       <= brw_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_SUB_CMP_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
`ifdef SEQ_SUB_CMP_EN
  assign lt = out_valid_q & bout_q;
  assign eq = out_valid_q & zero_q & ~bout_q;
`endif

endmodule

// File: tb/tb_seq_sub.sv
// Directed bench for seq_sub; builds with or without SEQ_SUB_CMP_EN.
module tb_seq_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
`ifdef SEQ_SUB_CMP_EN
  logic        lt;
  logic        eq;
`endif

  int checks   = 0;
  int failures = 0;

  seq_sub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SEQ_SUB_CMP_EN
    .lt        (lt),
    .eq        (eq),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One transaction: accept, wait for result, optionally hold it under backpressure, consume.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic bv_in,
                        input logic [15:0] exp_diff, input logic exp_bout, input logic exp_ovf,
                        input int hold, input bit check_lat);
    int lat;
    @(negedge clk);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = ~av; b = av ^ 16'h5555; bin = ~bv_in;
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat <= 20) begin
      @(negedge clk);
      if (!out_valid) lat++;
      else break;
    end
    if (lat > 20) begin
      chk("timeout", 32'(out_valid), 32'd1);
      return;
    end
    if (check_lat) chk("latency", 32'(lat), 32'd5);
    chk("diff", 32'(diff), 32'(exp_diff));
    chk("bout", 32'(bout), 32'(exp_bout));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
`ifdef SEQ_SUB_CMP_EN
    chk("lt", 32'(lt), 32'(exp_bout));
    chk("eq", 32'(eq), 32'((exp_diff == 16'h0) && !exp_bout));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a = 16'hDEAD ^ 16'(i); b = 16'h0BEE; bin = 1'b1;
      @(negedge clk);
      chk("hold_diff", 32'(diff), 32'(exp_diff));
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    $display("op a=%04h b=%04h bin=%0d -> diff=%04h bout=%0d ovf=%0d lat=%0d",
             av, bv, bv_in, diff, bout, ovf, lat);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // out_ready with nothing pending must not disturb the idle state.
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("spurious_ready_valid", 32'(out_valid), 32'd0);
    chk("spurious_ready_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 10, 1'b1);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b1);
    run_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    run_op(16'h5A5A, 16'h5A5A, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h0004, 16'h0005, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);

    // Abort mid-operation with reset.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_result", 32'(out_valid), 32'd0);
    $display("op abort a=1111 b=2222 -> in_ready=%0d out_valid=%0d", in_ready, out_valid);
    run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
